// File: rtl/regfile_ctrl_32_if.sv
// Request/response and register-file strobe bundle for regfile_ctrl_32.
// Latency: none; this is wiring only.
// Backpressure: req_valid/req_ready and rsp_valid/rsp_ready handshakes carried as-is.
//
// Ports (interface members):
//   req_valid/req_ready/req_write/req_addr/req_wdata : request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_addr           : read-response channel
//   init_done                                        : controller has left INIT
//   rf_inp/rf_inp_sel/rf_out_sel/rf_read/rf_write/rf_en/rf_out : register-file pins
// Modports: master = initiator plus register file; slave = the controller.
interface regfile_ctrl_32_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [4:0]        req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [4:0]        rsp_addr;
  logic              init_done;
  logic [DATA_W-1:0] rf_inp;
  logic [5:0]        rf_inp_sel;
  logic [5:0]        rf_out_sel;
  logic              rf_read;
  logic              rf_write;
  logic              rf_en;
  logic [DATA_W-1:0] rf_out;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, rf_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_addr, init_done,
           rf_inp, rf_inp_sel, rf_out_sel, rf_read, rf_write, rf_en
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, rf_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_addr, init_done,
           rf_inp, rf_inp_sel, rf_out_sel, rf_read, rf_write, rf_en
  );
endinterface

// File: rtl/regfile_ctrl_32.sv
// Access controller for a 32x32 register file: turns a request stream into EN/write/read strobes.
// Latency: write commits one edge after acceptance; read data valid one edge after acceptance.
// Backpressure: req_ready only in IDLE; a held response (rsp_ready=0) stalls new requests.
//
// Ports: clk, rst_n (async active-low); bus = regfile_ctrl_32_if.slave (request, response,
// init_done and register-file pins). Optional macro REGFILE_CTRL_INIT_EN compiles in a
// post-reset sweep that writes zero to registers 0..NREGS-1 before accepting requests.
module regfile_ctrl_32 #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  regfile_ctrl_32_if.slave bus
);

`ifdef REGFILE_CTRL_INIT_EN
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_WR, S_RD, S_RSP} state_t;
  localparam state_t     RST_STATE = S_INIT;
  localparam logic [4:0] LAST_IDX  = 5'(NREGS - 1);
  logic [4:0] r_cnt;
`else
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RSP} state_t;
  localparam state_t RST_STATE = S_IDLE;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [4:0]        r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [4:0]        r_rsp_addr;
  logic              r_rsp_valid;
  logic              r_init_done;

  logic              w_req_ready;
  logic              w_accept;
  logic              w_rf_en;
  logic              w_rf_write;
  logic              w_rf_read;
  logic [DATA_W-1:0] w_rf_inp;
  logic [4:0]        w_rf_inp_sel;

  // r_init_done also blocks the very first cycle after reset release.
  assign w_req_ready = (r_state == S_IDLE) && r_init_done;
  assign w_accept    = bus.req_valid && w_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RST_STATE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rf_en      = 1'b0;
    w_rf_write   = 1'b0;
    w_rf_read    = 1'b0;
    w_rf_inp     = '0;
    w_rf_inp_sel = 5'd0;
    case (r_state)
`ifdef REGFILE_CTRL_INIT_EN
      S_INIT: begin
        // The register file has no reset: the sweep strobes must stay quiet while
        // reset is held, even though the state register already sits in INIT.
        w_rf_en      = rst_n;
        w_rf_write   = rst_n;
        w_rf_inp_sel = r_cnt;
        if (r_cnt == LAST_IDX) w_state_nxt = S_IDLE;
      end
`endif
      S_IDLE: begin
        if (w_accept) w_state_nxt = bus.req_write ? S_WR : S_RD;
      end
      S_WR: begin
        w_rf_en      = 1'b1;
        w_rf_write   = 1'b1;
        w_rf_inp_sel = r_addr;
        w_rf_inp     = r_wdata;
        w_state_nxt  = S_IDLE;
      end
      S_RD: begin
        w_rf_en     = 1'b1;
        w_rf_read   = 1'b1;
        w_state_nxt = S_RSP;
      end
      S_RSP: begin
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture and read-response holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= 5'd0;
      r_wdata     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_addr  <= 5'd0;
      r_rsp_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      // rf_out settled on the falling edge inside RD.
      if (r_state == S_RD) begin
        r_rsp_rdata <= bus.rf_out;
        r_rsp_addr  <= r_addr;
        r_rsp_valid <= 1'b1;
      end else if ((r_state == S_RSP) && bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

`ifdef REGFILE_CTRL_INIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 5'd0;
      r_init_done <= 1'b0;
    end else if (r_state == S_INIT) begin
      r_cnt <= r_cnt + 5'd1;
      if (r_cnt == LAST_IDX) r_init_done <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_init_done <= 1'b0;
    else        r_init_done <= 1'b1;
  end
`endif

  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_rdata  = r_rsp_rdata;
  assign bus.rsp_addr   = r_rsp_addr;
  assign bus.init_done  = r_init_done;
  assign bus.rf_en      = w_rf_en;
  assign bus.rf_write   = w_rf_write;
  assign bus.rf_read    = w_rf_read;
  assign bus.rf_inp     = w_rf_inp;
  assign bus.rf_inp_sel = {1'b0, w_rf_inp_sel};
  assign bus.rf_out_sel = {1'b0, r_addr};

endmodule
